// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module  : hazard_ctrl_if
//  Purpose : Decode-side inputs and hazard/forwarding controls exchanged
//            between the pipeline datapath (master) and hazard_ctrl (slave).
//  Rev     : 1.0  initial release
// ============================================================================
interface hazard_ctrl_if #(
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
);
  logic              dec_valid;
  logic [REG_AW-1:0] dec_ra1;
  logic [REG_AW-1:0] dec_ra2;
  logic              dec_use1;
  logic              dec_use2;
  logic [REG_AW-1:0] dec_wa;
  logic              dec_regwrite;
  logic              dec_load;
  logic              br_taken_e;

  logic              stall_f;
  logic              stall_d;
  logic              flush_d;
  logic              flush_e;
  logic [1:0]        fwd_a_e;
  logic [1:0]        fwd_b_e;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output dec_valid, dec_ra1, dec_ra2, dec_use1, dec_use2,
           dec_wa, dec_regwrite, dec_load, br_taken_e,
    input  stall_f, stall_d, flush_d, flush_e, fwd_a_e, fwd_b_e,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  dec_valid, dec_ra1, dec_ra2, dec_use1, dec_use2,
           dec_wa, dec_regwrite, dec_load, br_taken_e,
    output stall_f, stall_d, flush_d, flush_e, fwd_a_e, fwd_b_e,
           stall_cnt, flush_cnt
  );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : hazard_ctrl
//  Purpose : Hazard detection, stall/flush generation and E-stage operand
//            forwarding for a 5-stage F/D/E/M/W core, with saturating
//            stall/flush performance counters.
//  Rev     : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
  parameter int REG_AW     = 4,
  parameter int PC_REG     = 15,
  parameter int ENABLE_FWD = 1,
  parameter int CNT_W      = 16
) (
  input  logic        clk,
  input  logic        rst,
  hazard_ctrl_if.slave hz
);

  localparam logic [REG_AW-1:0] PC_ADDR = REG_AW'(PC_REG);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  // Shadow of the E stage (sources kept for forwarding)
  logic              e_valid;
  logic [REG_AW-1:0] e_wa;
  logic              e_regwrite;
  logic              e_load;
  logic              e_pcwrite;
  logic [REG_AW-1:0] e_ra1;
  logic [REG_AW-1:0] e_ra2;
  logic              e_use1;
  logic              e_use2;

  // Shadow of the M stage
  logic              m_valid;
  logic [REG_AW-1:0] m_wa;
  logic              m_regwrite;
  logic              m_load;
  logic              m_pcwrite;

  // Shadow of the W stage; its load/PC-write flags are never consulted
  // (nothing is blocked or filtered once the writer has reached W)
  logic              w_valid;
  logic [REG_AW-1:0] w_wa;
  logic              w_regwrite;

  logic              load_stall;
  logic              pc_pend;
  logic              dec_pcwrite;
  logic              e_load_en;
  logic              stall_d;
  logic              flush_e;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  // A source depends on an in-flight writer; the PC alias is never a match
  function automatic logic src_match(
    input logic              use_bit,
    input logic [REG_AW-1:0] src,
    input logic              ent_valid,
    input logic              ent_regwrite,
    input logic [REG_AW-1:0] ent_wa
  );
    return use_bit && ent_valid && ent_regwrite &&
           (src == ent_wa) && (src != PC_ADDR);
  endfunction

  assign dec_pcwrite = hz.dec_regwrite && (hz.dec_wa == PC_ADDR);

  generate
    if (ENABLE_FWD != 0) begin : g_fwd
      // Only a load still in E cannot be forwarded in time
      always_comb begin
        load_stall = hz.dec_valid && e_load &&
                     (src_match(hz.dec_use1, hz.dec_ra1, e_valid, e_regwrite, e_wa) ||
                      src_match(hz.dec_use2, hz.dec_ra2, e_valid, e_regwrite, e_wa));
      end

      // Operand select for E: M ALU result wins over W, loads in M are skipped
      always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (e_valid && !m_load && src_match(e_use1, e_ra1, m_valid, m_regwrite, m_wa))
          fwd_a = 2'b10;
        else if (e_valid && src_match(e_use1, e_ra1, w_valid, w_regwrite, w_wa))
          fwd_a = 2'b01;
        if (e_valid && !m_load && src_match(e_use2, e_ra2, m_valid, m_regwrite, m_wa))
          fwd_b = 2'b10;
        else if (e_valid && src_match(e_use2, e_ra2, w_valid, w_regwrite, w_wa))
          fwd_b = 2'b01;
      end
    end else begin : g_nofwd
      // No bypass and no register-file write-through: wait until W retires
      always_comb begin
        load_stall = hz.dec_valid &&
                     (src_match(hz.dec_use1, hz.dec_ra1, e_valid, e_regwrite, e_wa) ||
                      src_match(hz.dec_use2, hz.dec_ra2, e_valid, e_regwrite, e_wa) ||
                      src_match(hz.dec_use1, hz.dec_ra1, m_valid, m_regwrite, m_wa) ||
                      src_match(hz.dec_use2, hz.dec_ra2, m_valid, m_regwrite, m_wa) ||
                      src_match(hz.dec_use1, hz.dec_ra1, w_valid, w_regwrite, w_wa) ||
                      src_match(hz.dec_use2, hz.dec_ra2, w_valid, w_regwrite, w_wa));
      end

      // Selects are tied to the register file
      always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
      end
    end
  endgenerate

  // Fetch stays blocked while a PC writer is in D, E or M
  always_comb begin
    pc_pend = (hz.dec_valid && dec_pcwrite) ||
              (e_valid && e_pcwrite) ||
              (m_valid && m_pcwrite);
  end

  // Taken branch overrides any stall: the stalled instruction is wrong-path
  always_comb begin
    stall_d   = load_stall && !hz.br_taken_e;
    flush_e   = load_stall || hz.br_taken_e;
    e_load_en = hz.dec_valid && !(stall_d || flush_e);
  end

  assign hz.stall_f   = (load_stall || pc_pend) && !hz.br_taken_e;
  assign hz.stall_d   = stall_d;
  assign hz.flush_e   = flush_e;
  assign hz.flush_d   = (pc_pend && !stall_d) || hz.br_taken_e;
  assign hz.fwd_a_e   = fwd_a;
  assign hz.fwd_b_e   = fwd_b;
  assign hz.stall_cnt = stall_cnt;
  assign hz.flush_cnt = flush_cnt;

  // Shadow pipeline: D->E when the instruction is accepted, E->M->W always
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_valid    <= 1'b0;
      e_wa       <= '0;
      e_regwrite <= 1'b0;
      e_load     <= 1'b0;
      e_pcwrite  <= 1'b0;
      e_ra1      <= '0;
      e_ra2      <= '0;
      e_use1     <= 1'b0;
      e_use2     <= 1'b0;
      m_valid    <= 1'b0;
      m_wa       <= '0;
      m_regwrite <= 1'b0;
      m_load     <= 1'b0;
      m_pcwrite  <= 1'b0;
      w_valid    <= 1'b0;
      w_wa       <= '0;
      w_regwrite <= 1'b0;
    end else begin
      e_valid    <= e_load_en;
      e_wa       <= hz.dec_wa;
      e_regwrite <= hz.dec_regwrite;
      e_load     <= hz.dec_load;
      e_pcwrite  <= dec_pcwrite;
      e_ra1      <= hz.dec_ra1;
      e_ra2      <= hz.dec_ra2;
      e_use1     <= hz.dec_use1;
      e_use2     <= hz.dec_use2;
      m_valid    <= e_valid;
      m_wa       <= e_wa;
      m_regwrite <= e_regwrite;
      m_load     <= e_load;
      m_pcwrite  <= e_pcwrite;
      w_valid    <= m_valid;
      w_wa       <= m_wa;
      w_regwrite <= m_regwrite;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_d && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + 1'b1;
      if (hz.br_taken_e && (flush_cnt != CNT_MAX))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_hazard_ctrl
//  Purpose : Directed self-checking bench for hazard_ctrl in forwarding,
//            stall-only and narrow-counter configurations.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  hazard_ctrl_if #(.REG_AW(4), .CNT_W(16)) if_f ();
  hazard_ctrl_if #(.REG_AW(4), .CNT_W(16)) if_n ();
  hazard_ctrl_if #(.REG_AW(4), .CNT_W(2))  if_s ();

  hazard_ctrl #(.REG_AW(4), .PC_REG(15), .ENABLE_FWD(1), .CNT_W(16)) u_fwd (
    .clk(clk), .rst(rst), .hz(if_f));
  hazard_ctrl #(.REG_AW(4), .PC_REG(15), .ENABLE_FWD(0), .CNT_W(16)) u_nofwd (
    .clk(clk), .rst(rst), .hz(if_n));
  hazard_ctrl #(.REG_AW(4), .PC_REG(15), .ENABLE_FWD(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .hz(if_s));

  // Packed control view: {stall_f, stall_d, flush_d, flush_e, fwd_a, fwd_b}
  logic [7:0] ctl_f;
  logic [7:0] ctl_n;
  logic [7:0] ctl_s;
  assign ctl_f = {if_f.stall_f, if_f.stall_d, if_f.flush_d, if_f.flush_e, if_f.fwd_a_e, if_f.fwd_b_e};
  assign ctl_n = {if_n.stall_f, if_n.stall_d, if_n.flush_d, if_n.flush_e, if_n.fwd_a_e, if_n.fwd_b_e};
  assign ctl_s = {if_s.stall_f, if_s.stall_d, if_s.flush_d, if_s.flush_e, if_s.fwd_a_e, if_s.fwd_b_e};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int which, input logic v,
                     input logic [3:0] ra1, input logic [3:0] ra2,
                     input logic u1, input logic u2, input logic [3:0] wa,
                     input logic rw, input logic ld, input logic br);
    case (which)
      0: begin
        if_f.dec_valid = v; if_f.dec_ra1 = ra1; if_f.dec_ra2 = ra2;
        if_f.dec_use1 = u1; if_f.dec_use2 = u2; if_f.dec_wa = wa;
        if_f.dec_regwrite = rw; if_f.dec_load = ld; if_f.br_taken_e = br;
      end
      1: begin
        if_n.dec_valid = v; if_n.dec_ra1 = ra1; if_n.dec_ra2 = ra2;
        if_n.dec_use1 = u1; if_n.dec_use2 = u2; if_n.dec_wa = wa;
        if_n.dec_regwrite = rw; if_n.dec_load = ld; if_n.br_taken_e = br;
      end
      default: begin
        if_s.dec_valid = v; if_s.dec_ra1 = ra1; if_s.dec_ra2 = ra2;
        if_s.dec_use1 = u1; if_s.dec_use2 = u2; if_s.dec_wa = wa;
        if_s.dec_regwrite = rw; if_s.dec_load = ld; if_s.br_taken_e = br;
      end
    endcase
  endtask

  task automatic idle(input int which);
    drv(which, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic drain(input int which);
    idle(which);
    repeat (3) step();
  endtask

  // Instruction shorthands used below:
  //   ADD r1,r2,r3 : ra1=2 ra2=3 wa=1     SUB r2,r1,r3 : ra1=1 ra2=3 wa=2
  //   LDR r4,[r0]  : ra1=0 wa=4 load      ADD r5,r4,r4 : ra1=4 ra2=4 wa=5
  //   MOV r15,...  : wa=15 (PC write)
  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle(0); idle(1); idle(2);

    // Reset state
    repeat (2) @(posedge clk);
    settle();
    chk("reset_ctl_fwd",   32'(ctl_f), 32'h00);
    chk("reset_ctl_nofwd", 32'(ctl_n), 32'h00);
    chk("reset_stall_cnt", 32'(if_f.stall_cnt), 32'd0);
    chk("reset_flush_cnt", 32'(if_f.flush_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();

    // Back-to-back ADD/SUB: no stall, SUB takes M result
    drv(0, 1'b1, 4'd2, 4'd3, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
    settle(); chk("b2b_add_in_d", 32'(ctl_f), 32'h00); step();
    drv(0, 1'b1, 4'd1, 4'd3, 1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
    settle(); chk("b2b_sub_in_d", 32'(ctl_f), 32'h00); step();
    idle(0);
    settle(); chk("b2b_fwd_m", 32'(ctl_f), 32'h08); step();
    drain(0);

    // One NOP between: SUB takes W result
    drv(0, 1'b1, 4'd2, 4'd3, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0); step();
    idle(0); step();
    drv(0, 1'b1, 4'd1, 4'd3, 1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
    settle(); chk("nop_sub_in_d", 32'(ctl_f), 32'h00); step();
    idle(0);
    settle(); chk("nop_fwd_w", 32'(ctl_f), 32'h04); step();
    drain(0);

    // Load-use: exactly one stall, then both operands from W
    drv(0, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0, 4'd4, 1'b1, 1'b1, 1'b0);
    settle(); chk("lu_ldr_in_d", 32'(ctl_f), 32'h00); step();
    drv(0, 1'b1, 4'd4, 4'd4, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
    settle(); chk("lu_stall", 32'(ctl_f), 32'hD0); step();
    settle(); chk("lu_released", 32'(ctl_f), 32'h00); step();
    idle(0);
    settle(); chk("lu_fwd_w", 32'(ctl_f), 32'h05);
    chk("lu_stall_cnt", 32'(if_f.stall_cnt), 32'd1); step();
    drain(0);

    // Stall-only mode: three stall cycles, selects stay at register file
    drv(1, 1'b1, 4'd2, 4'd3, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
    settle(); chk("nf_add_in_d", 32'(ctl_n), 32'h00); step();
    drv(1, 1'b1, 4'd1, 4'd3, 1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      settle(); chk($sformatf("nf_stall_%0d", i), 32'(ctl_n), 32'hD0); step();
    end
    settle(); chk("nf_released", 32'(ctl_n), 32'h00); step();
    idle(1);
    settle(); chk("nf_sub_in_e", 32'(ctl_n), 32'h00);
    chk("nf_stall_cnt", 32'(if_n.stall_cnt), 32'd3); step();
    drain(1);

    // PC write blocks fetch for three cycles
    drv(0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd15, 1'b1, 1'b0, 1'b0);
    settle(); chk("pc_in_d", 32'(ctl_f), 32'hA0); step();
    idle(0);
    settle(); chk("pc_in_e", 32'(ctl_f), 32'hA0); step();
    settle(); chk("pc_in_m", 32'(ctl_f), 32'hA0); step();
    drv(0, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0, 4'd4, 1'b1, 1'b1, 1'b0);
    settle(); chk("pc_in_w_free", 32'(ctl_f), 32'h00); step();
    // Taken branch with a pending load-use stall
    drv(0, 1'b1, 4'd4, 4'd4, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b1);
    settle(); chk("br_over_stall", 32'(ctl_f), 32'h30); step();
    idle(0);
    settle(); chk("br_after", 32'(ctl_f), 32'h00);
    chk("br_flush_cnt", 32'(if_f.flush_cnt), 32'd1);
    chk("br_stall_cnt_kept", 32'(if_f.stall_cnt), 32'd1); step();
    drain(0);

    // Narrow counter saturates at 3
    drv(2, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(); settle();
      chk($sformatf("sat_flush_cnt_%0d", i), 32'(if_s.flush_cnt), (i < 2) ? 32'(i + 1) : 32'd3);
    end
    step();
    idle(2);
    step();

    // Reset asserted mid-stall: outputs drop at once, nothing survives
    drv(0, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0, 4'd4, 1'b1, 1'b1, 1'b0); step();
    drv(0, 1'b1, 4'd4, 4'd4, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
    settle(); chk("rst_pre_stall", 32'(ctl_f), 32'hD0);
    rst = 1'b1;
    #1;
    chk("rst_mid_ctl", 32'(ctl_f), 32'h00);
    chk("rst_mid_stall_cnt", 32'(if_f.stall_cnt), 32'd0);
    chk("rst_mid_flush_cnt", 32'(if_f.flush_cnt), 32'd0);
    idle(0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    settle(); chk("rst_post_ctl0", 32'(ctl_f), 32'h00); step();
    settle(); chk("rst_post_ctl1", 32'(ctl_f), 32'h00);
    chk("rst_post_stall_cnt", 32'(if_f.stall_cnt), 32'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
